// File: rtl/rps_draw_scheduler.sv
// Rock-paper-scissors frame painter: arbitrates user/computer draw requests and
// rasters one 80x120 half of the screen from a 1-cycle-latency glyph ROM.
module rps_draw_scheduler #(
  parameter logic [2:0] BG_USER = 3'b000,
  parameter logic [2:0] BG_COMP = 3'b111,
  parameter logic [2:0] FG      = 3'b010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_user,
  input  logic [1:0]  choice_user,
  input  logic        req_comp,
  input  logic [1:0]  choice_comp,
  input  logic        rom_q,
  output logic [14:0] rom_addr,
  output logic [1:0]  rom_sel,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done,
  output logic        grant_comp
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} state_t;

  state_t      state, state_next;
  logic        pend_user, pend_comp;
  logic        prefer_comp;
  logic [1:0]  cap_user, cap_comp;
  logic [7:0]  base, xc;
  logic [6:0]  yc;
  logic        grant, grant_to_comp, row_end, last_addr;
  logic [14:0] scan_addr;

  // prefer_comp is separate from grant_comp so the first contested grant after
  // reset still goes to the user while grant_comp reads 0.
  always_comb begin
    grant         = (state == IDLE) && (pend_user || pend_comp);
    grant_to_comp = pend_comp && (!pend_user || prefer_comp);
    row_end       = (xc == base + 8'd79);
    last_addr     = row_end && (yc == 7'd119);
    scan_addr     = {1'b0, yc, 7'b0} + {3'b0, yc, 5'b0} + {7'b0, xc};
    state_next    = state;
    case (state)
      IDLE:    if (grant) state_next = SCAN;
      SCAN:    if (last_addr) state_next = FLUSH;
      FLUSH:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_user   <= 1'b0;
      pend_comp   <= 1'b0;
      prefer_comp <= 1'b0;
      cap_user    <= '0;
      cap_comp    <= '0;
      grant_comp  <= 1'b0;
      rom_sel     <= '0;
      base        <= '0;
      xc          <= '0;
      yc          <= '0;
      x           <= '0;
      y           <= '0;
      plot        <= 1'b0;
    end else begin
      pend_user <= req_user | (pend_user & ~(grant & ~grant_to_comp));
      pend_comp <= req_comp | (pend_comp & ~(grant & grant_to_comp));
      if (req_user) cap_user <= choice_user;
      if (req_comp) cap_comp <= choice_comp;
      if (grant) begin
        grant_comp  <= grant_to_comp;
        prefer_comp <= ~grant_to_comp;
        rom_sel     <= grant_to_comp ? cap_comp : cap_user;
        base        <= grant_to_comp ? 8'd80 : 8'd0;
        xc          <= grant_to_comp ? 8'd80 : 8'd0;
        yc          <= '0;
      end else if (state == SCAN) begin
        if (row_end) begin
          xc <= base;
          yc <= yc + 7'd1;
        end else begin
          xc <= xc + 8'd1;
        end
      end
      // Pixel coordinates trail the address by the ROM's one-cycle latency.
      x    <= xc;
      y    <= yc;
      plot <= (state == SCAN);
    end
  end

  always_comb begin
    rom_addr = (state == SCAN) ? scan_addr : '0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    colour   = '0;
    if (plot) colour = rom_q ? (grant_comp ? BG_COMP : BG_USER) : FG;
  end

endmodule
